// File: rtl/oser_pio_tx.sv
// Output-side PIO serializer: parallel words in over VALID/READY, LSB-first serial out on Q with tristate TQ.
// Optional even-parity slot after the last data bit when OSER_PARITY_EN is defined.
module oser_pio_tx #(
   parameter int   WIDTH    = 4,
   parameter logic IDLE_VAL = 1'b1
) (
   input  logic             SCLK,
   input  logic             CDN,
   input  logic             SP,
   input  logic [WIDTH-1:0] DATA,
   input  logic             VALID,
   output logic             READY,
   output logic             Q,
   output logic             TQ,
   output logic             BUSY
);

`ifdef OSER_PARITY_EN
   localparam int LAST = WIDTH;
`else
   localparam int LAST = WIDTH - 1;
`endif
   localparam int SW = LAST + 1;
   localparam int CW = $clog2(LAST + 1);
   localparam logic [CW-1:0] LAST_C = CW'(LAST);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    shift_q, shift_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             q_q, q_d;
   logic             tq_q, tq_d;
   logic             rdy_en_q;
   logic             accept;
   logic             last_slot;
   logic [SW-1:0]    load_word;

`ifdef OSER_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] w);
      return ^w;
   endfunction

   assign load_word = {even_parity(hold_q), hold_q};
`else
   assign load_word = hold_q;
`endif

   // rdy_en_q keeps READY low during reset and for the first edge after release
   assign READY     = rdy_en_q & ~hold_full_q;
   assign BUSY      = (state_q == ST_SHIFT) | hold_full_q;
   assign Q         = q_q;
   assign TQ        = tq_q;
   assign accept    = SP & VALID & READY;
   assign last_slot = (state_q == ST_SHIFT) && (cnt_q == LAST_C);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      q_d         = q_q;
      tq_d        = tq_q;
      if (SP) begin
         // accept only happens with the holding register empty, so it never races a load
         if (accept) begin
            hold_d      = DATA;
            hold_full_d = 1'b1;
         end
         if (((state_q == ST_IDLE) || last_slot) && hold_full_q) begin
            shift_d     = load_word;
            cnt_d       = '0;
            state_d     = ST_SHIFT;
            hold_full_d = 1'b0;
            q_d         = hold_q[0];
            tq_d        = 1'b0;
         end else if ((state_q == ST_SHIFT) && !last_slot) begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            q_d     = shift_q[1];
            tq_d    = 1'b0;
         end else if (last_slot) begin
            state_d = ST_IDLE;
            q_d     = IDLE_VAL;
            tq_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge SCLK or negedge CDN) begin
      if (!CDN) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hold_full_q <= 1'b0;
         q_q         <= IDLE_VAL;
         tq_q        <= 1'b1;
         rdy_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_full_q <= hold_full_d;
         q_q         <= q_d;
         tq_q        <= tq_d;
         rdy_en_q    <= 1'b1;
      end
   end

   // Data registers carry no reset; hold_full_q and state_q qualify their contents
   always_ff @(posedge SCLK) begin
      shift_q <= shift_d;
      hold_q  <= hold_d;
   end

endmodule

// File: tb/tb_oser_pio_tx.sv
// Directed bench for oser_pio_tx (WIDTH=4, IDLE_VAL=1); vector table plus hand-written reset sequences.
module tb_oser_pio_tx;
   logic       clk;
   logic       cdn;
   logic       sp;
   logic [3:0] data;
   logic       valid;
   logic       ready;
   logic       q;
   logic       tq;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       sp;
      logic       valid;
      logic [3:0] data;
      logic       q;
      logic       tq;
      logic       rdy;
      logic       busy;
   } vec_t;

   vec_t vecs[$];

   oser_pio_tx #(.WIDTH(4), .IDLE_VAL(1'b1)) dut (
      .SCLK (clk),
      .CDN  (cdn),
      .SP   (sp),
      .DATA (data),
      .VALID(valid),
      .READY(ready),
      .Q    (q),
      .TQ   (tq),
      .BUSY (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic eq, input logic etq,
                          input logic erdy, input logic ebusy);
      chk({tag, ".Q"}, q, eq);
      chk({tag, ".TQ"}, tq, etq);
      chk({tag, ".READY"}, ready, erdy);
      chk({tag, ".BUSY"}, busy, ebusy);
   endtask

   task automatic add(input logic s, input logic v, input logic [3:0] d,
                      input logic eq, input logic etq, input logic erdy, input logic ebusy);
      vec_t r;
      r.sp = s; r.valid = v; r.data = d;
      r.q = eq; r.tq = etq; r.rdy = erdy; r.busy = ebusy;
      vecs.push_back(r);
   endtask

   // Drive one row before an edge, check outputs 1 time unit after it
   task automatic apply(input int idx);
      sp    = vecs[idx].sp;
      valid = vecs[idx].valid;
      data  = vecs[idx].data;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", idx), vecs[idx].q, vecs[idx].tq, vecs[idx].rdy, vecs[idx].busy);
   endtask

   initial begin
`ifdef OSER_PARITY_EN
      // 0111, parity 1: Q = 1,1,1,0,1
      add(1, 1, 4'h7, 1, 1, 0, 1);
      add(1, 0, 4'h0, 1, 0, 1, 1);
      add(1, 0, 4'h0, 1, 0, 1, 1);
      add(1, 0, 4'h0, 1, 0, 1, 1);
      add(1, 0, 4'h0, 0, 0, 1, 1);
      add(1, 0, 4'h0, 1, 0, 1, 1);
      add(1, 0, 4'h0, 1, 1, 1, 0);
`else
      // single word 0110
      add(1, 1, 4'h6, 1, 1, 0, 1);
      add(1, 0, 4'h0, 0, 0, 1, 1);
      add(1, 0, 4'h0, 1, 0, 1, 1);
      add(1, 0, 4'h0, 1, 0, 1, 1);
      add(1, 0, 4'h0, 0, 0, 1, 1);
      add(1, 0, 4'h0, 1, 1, 1, 0);
      // back-to-back A then 5
      add(1, 1, 4'hA, 1, 1, 0, 1);
      add(1, 1, 4'h5, 0, 0, 1, 1);
      add(1, 1, 4'h5, 1, 0, 0, 1);
      add(1, 0, 4'h0, 0, 0, 0, 1);
      add(1, 0, 4'h0, 1, 0, 0, 1);
      add(1, 0, 4'h0, 1, 0, 1, 1);
      add(1, 0, 4'h0, 0, 0, 1, 1);
      add(1, 0, 4'h0, 1, 0, 1, 1);
      add(1, 0, 4'h0, 0, 0, 1, 1);
      add(1, 0, 4'h0, 1, 1, 1, 0);
      // C with SP low for 3 cycles after bit 1
      add(1, 1, 4'hC, 1, 1, 0, 1);
      add(1, 0, 4'h0, 0, 0, 1, 1);
      add(1, 0, 4'h0, 0, 0, 1, 1);
      add(0, 1, 4'hF, 0, 0, 1, 1);
      add(0, 1, 4'hF, 0, 0, 1, 1);
      add(0, 1, 4'hF, 0, 0, 1, 1);
      add(1, 0, 4'h0, 1, 0, 1, 1);
      add(1, 0, 4'h0, 1, 0, 1, 1);
      add(1, 0, 4'h0, 1, 1, 1, 0);
`endif

      cdn   = 1'b0;
      sp    = 1'b0;
      valid = 1'b0;
      data  = 4'h0;
      #12;
      chk_all("reset", 1'b1, 1'b1, 1'b0, 1'b0);
      cdn = 1'b1;
      #1;
      chk("release.READY_before_edge", ready, 1'b0);
      @(posedge clk);
      #1;
      chk_all("release", 1'b1, 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < vecs.size(); i++) apply(i);

      // 0011 in flight with F held, reset during bit 2
      sp = 1'b1; valid = 1'b1; data = 4'h3;
      @(posedge clk); #1;
      chk_all("rst.acc3", 1'b1, 1'b1, 1'b0, 1'b1);
      data = 4'hF;
      @(posedge clk); #1;
      chk_all("rst.bit0", 1'b1, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      chk_all("rst.bit1", 1'b1, 1'b0, 1'b0, 1'b1);
      valid = 1'b0;
      @(posedge clk); #1;
      chk_all("rst.bit2", 1'b0, 1'b0, 1'b0, 1'b1);
      #2 cdn = 1'b0;
      #1;
      chk_all("rst.async", 1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 cdn = 1'b1;
      #1;
      chk("rst.READY_before_edge", ready, 1'b0);
      @(posedge clk); #1;
      chk_all("rst.release", 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk_all($sformatf("rst.idle%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
